fd_tag_arbiter: RTL and testbench

- Shares a single timestamp readout path between g_num_ch per-channel timestamper sources.
- Each source delivers a one-cycle tag pulse with a UTC/coarse/frac timestamp; the block holds one pending tag per channel.
- A round-robin scheduler grants pending tags into a registered valid/ready output stage, each stamped with channel number and sequence count.
- The output feeds the tag readout buffer; per-channel overflow is reported to the control registers.

---
 rtl/fd_tag_pkg.sv | 22 ++
 rtl/fd_rr_arbiter.sv | 66 ++++++
 rtl/fd_tag_arbiter.sv | 150 +++++++++++++++
 tb/tb_fd_tag_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_tag_pkg.sv
// ============================================================================
// fd_tag_pkg : shared timestamp types and constants for the tag arbiter
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package fd_tag_pkg;

    localparam int c_utc_width    = 32;
    localparam int c_coarse_width = 28;
    localparam int c_frac_width   = 12;
    localparam int c_coarse_range = 125000000;

    typedef struct packed {
        logic [c_utc_width-1:0]    utc;
        logic [c_coarse_width-1:0] coarse;
        logic [c_frac_width-1:0]   frac;
    } t_fd_timestamp;

endpackage

`default_nettype wire

// File: rtl/fd_rr_arbiter.sv
// ============================================================================
// fd_rr_arbiter : round-robin request selector with a registered pointer
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module fd_rr_arbiter #(
    parameter int g_num_ch = 4
) (
    input  logic                clk_ref_i,
    input  logic                rst_n_i,
    input  logic [g_num_ch-1:0] req_i,
    input  logic                adv_i,
    output logic [g_num_ch-1:0] gnt_o,
    output logic [2:0]          idx_o,
    output logic                any_o
);

    logic [2:0] ptr_q, ptr_d;
    logic [7:0] req_ext;

    assign req_ext = 8'(req_i);

    // Search upward from the pointer, wrapping modulo g_num_ch.
    always_comb begin
        logic [3:0] c;
        c     = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < g_num_ch; i++) begin
            c = {1'b0, ptr_q} + 4'(i);
            if (c >= 4'(g_num_ch)) begin
                c = c - 4'(g_num_ch);
            end
            if (!any_o && req_ext[c[2:0]]) begin
                any_o = 1'b1;
                idx_o = c[2:0];
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < g_num_ch; k++) begin
            gnt_o[k] = any_o && (idx_o == 3'(k));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && any_o) begin
            ptr_d = (idx_o == 3'(g_num_ch - 1)) ? 3'd0 : idx_o + 3'd1;
        end
    end

    always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fd_tag_arbiter.sv
// ============================================================================
// fd_tag_arbiter : merges per-channel timestamp tags into one valid/ready
//                  stream stamped with channel index and sequence number
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module fd_tag_arbiter
    import fd_tag_pkg::*;
#(
    parameter int g_num_ch    = 4,
    parameter int g_seq_width = 16
) (
    input  logic                   clk_ref_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic [g_num_ch-1:0]    ch_valid_i,
    input  logic [32*g_num_ch-1:0] ch_utc_i,
    input  logic [28*g_num_ch-1:0] ch_coarse_i,
    input  logic [12*g_num_ch-1:0] ch_frac_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_utc_o,
    output logic [27:0]            out_coarse_o,
    output logic [11:0]            out_frac_o,
    output logic [2:0]             out_channel_o,
    output logic [g_seq_width-1:0] out_seq_o,
    output logic [g_num_ch-1:0]    ovf_o,
    input  logic [g_num_ch-1:0]    ovf_clr_i
);

    t_fd_timestamp          ch_ts [g_num_ch];
    t_fd_timestamp          pend_q [g_num_ch];
    logic [g_num_ch-1:0]    pend_v_q, pend_v_d;
    logic [g_num_ch-1:0]    ovf_q, ovf_d;
    logic [g_num_ch-1:0]    load_v;
    logic [g_num_ch-1:0]    arb_gnt, gnt_v;
    logic [2:0]             arb_idx;
    logic                   arb_any;
    logic                   load_en, grant;
    t_fd_timestamp          sel_ts;

    logic                   out_valid_q;
    t_fd_timestamp          out_ts_q;
    logic [2:0]             out_ch_q;
    logic [g_seq_width-1:0] out_seq_q, seq_q;

    for (genvar k = 0; k < g_num_ch; k++) begin : g_unpack
        assign ch_ts[k].utc    = ch_utc_i[32*k +: 32];
        assign ch_ts[k].coarse = ch_coarse_i[28*k +: 28];
        assign ch_ts[k].frac   = ch_frac_i[12*k +: 12];
    end

    assign load_en = !out_valid_q || out_ready_i;
    assign grant   = load_en && arb_any;
    assign gnt_v   = arb_gnt & {g_num_ch{grant}};

    fd_rr_arbiter #(
        .g_num_ch (g_num_ch)
    ) u_arb (
        .clk_ref_i (clk_ref_i),
        .rst_n_i   (rst_n_i),
        .req_i     (pend_v_q),
        .adv_i     (load_en),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .any_o     (arb_any)
    );

    // A slot freed by a grant this cycle may accept a new tag without overflow.
    always_comb begin
        logic cap;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        load_v   = '0;
        cap      = 1'b0;
        for (int k = 0; k < g_num_ch; k++) begin
            cap = ch_valid_i[k] && enable_i;
            if (gnt_v[k]) begin
                pend_v_d[k] = 1'b0;
            end
            ovf_d[k] = ovf_q[k] && !ovf_clr_i[k];
            if (cap) begin
                if (!pend_v_q[k] || gnt_v[k]) begin
                    pend_v_d[k] = 1'b1;
                    load_v[k]   = 1'b1;
                end else begin
                    ovf_d[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_ts = '0;
        for (int k = 0; k < g_num_ch; k++) begin
            if (arb_gnt[k]) begin
                sel_ts = pend_q[k];
            end
        end
    end

    always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_v_q <= '0;
            ovf_q    <= '0;
            for (int k = 0; k < g_num_ch; k++) begin
                pend_q[k] <= '0;
            end
        end else begin
            pend_v_q <= pend_v_d;
            ovf_q    <= ovf_d;
            for (int k = 0; k < g_num_ch; k++) begin
                if (load_v[k]) begin
                    pend_q[k] <= ch_ts[k];
                end
            end
        end
    end

    // Data fields only change on a grant; an idle load just drops valid.
    always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_ts_q    <= '0;
            out_ch_q    <= '0;
            out_seq_q   <= '0;
            seq_q       <= '0;
        end else if (load_en) begin
            out_valid_q <= arb_any;
            if (arb_any) begin
                out_ts_q  <= sel_ts;
                out_ch_q  <= arb_idx;
                out_seq_q <= seq_q;
                seq_q     <= seq_q + 1'b1;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_utc_o     = out_ts_q.utc;
    assign out_coarse_o  = out_ts_q.coarse;
    assign out_frac_o    = out_ts_q.frac;
    assign out_channel_o = out_ch_q;
    assign out_seq_o     = out_seq_q;
    assign ovf_o         = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fd_tag_arbiter.sv
// ============================================================================
// tb_fd_tag_arbiter : scoreboard bench for fd_tag_arbiter (4 channels, 4-bit seq)
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fd_tag_arbiter;

    localparam int NCH = 4;
    localparam int SW  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b1;
    logic             ready = 1'b0;
    logic [NCH-1:0]   ch_valid = '0;
    logic [NCH-1:0]   ovf_clr = '0;
    logic [32*NCH-1:0] utc = '0;
    logic [28*NCH-1:0] coarse = '0;
    logic [12*NCH-1:0] frac = '0;

    logic             out_valid;
    logic [31:0]      out_utc;
    logic [27:0]      out_coarse;
    logic [11:0]      out_frac;
    logic [2:0]       out_channel;
    logic [SW-1:0]    out_seq;
    logic [NCH-1:0]   ovf;

    fd_tag_arbiter #(
        .g_num_ch    (NCH),
        .g_seq_width (SW)
    ) dut (
        .clk_ref_i     (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .ch_valid_i    (ch_valid),
        .ch_utc_i      (utc),
        .ch_coarse_i   (coarse),
        .ch_frac_i     (frac),
        .out_valid_o   (out_valid),
        .out_ready_i   (ready),
        .out_utc_o     (out_utc),
        .out_coarse_o  (out_coarse),
        .out_frac_o    (out_frac),
        .out_channel_o (out_channel),
        .out_seq_o     (out_seq),
        .ovf_o         (ovf),
        .ovf_clr_i     (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    ch;
        logic [31:0]   utc;
        logic [27:0]   coarse;
        logic [11:0]   frac;
        logic [SW-1:0] seq;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [SW-1:0] exp_seq  = '0;
    int            tagn     = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Every accepted output tag is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && ready) begin
            check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("out_channel", 64'(out_channel), 64'(e.ch));
                check_eq("out_utc",     64'(out_utc),     64'(e.utc));
                check_eq("out_coarse",  64'(out_coarse),  64'(e.coarse));
                check_eq("out_frac",    64'(out_frac),    64'(e.frac));
                check_eq("out_seq",     64'(out_seq),     64'(e.seq));
            end
        end
    end

    task automatic set_ch(input int k, input logic [31:0] u, input logic [27:0] c,
                          input logic [11:0] f, input bit push);
        exp_t e;
        ch_valid[k]         = 1'b1;
        utc[32*k +: 32]     = u;
        coarse[28*k +: 28]  = c;
        frac[12*k +: 12]    = f;
        if (push) begin
            e.ch = 3'(k); e.utc = u; e.coarse = c; e.frac = f; e.seq = exp_seq;
            sb.push_back(e);
            exp_seq = exp_seq + 1'b1;
        end
    endtask

    task automatic set_auto(input int k, input bit push);
        tagn++;
        set_ch(k, 32'(tagn * 7 + k + 1), 28'((tagn * 1013 + k) % 125000000),
               12'((tagn * 37 + k) & 12'hfff), push);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ch_valid = '0;
        ovf_clr  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (sb.size() != 0 && i < 60) begin
            tick();
            i++;
        end
        tick();
        check_eq({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_seq = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        do_reset();
        check_eq("rst_valid",  64'(out_valid),   64'd0);
        check_eq("rst_utc",    64'(out_utc),     64'd0);
        check_eq("rst_coarse", 64'(out_coarse),  64'd0);
        check_eq("rst_frac",   64'(out_frac),    64'd0);
        check_eq("rst_chan",   64'(out_channel), 64'd0);
        check_eq("rst_seq",    64'(out_seq),     64'd0);
        check_eq("rst_ovf",    64'(ovf),         64'd0);

        // Single tag: two-cycle latency, fields pass through unchanged.
        ready = 1'b1;
        idle(2);
        set_ch(2, 32'd5, 28'd1000, 12'h123, 1'b1);
        tick();
        check_eq("lat_t1_valid", 64'(out_valid), 64'd0);
        tick();
        check_eq("lat_t2_valid", 64'(out_valid), 64'd1);
        drain("single");

        // Simultaneous strobes from a fresh pointer, then 0+3 after wrap.
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < NCH; k++) set_auto(k, 1'b1);
        tick();
        drain("simul");
        set_auto(0, 1'b1);
        set_auto(3, 1'b1);
        tick();
        drain("simul03");

        // Backpressure: ch0 occupies the output, second ch1 tag overflows.
        do_reset();
        ready = 1'b0;
        set_auto(0, 1'b1);
        tick();
        tick();
        set_auto(1, 1'b1);
        tick();
        idle(2);
        set_auto(1, 1'b0);
        tick();
        check_eq("bp_ovf",     64'(ovf),         64'b0010);
        check_eq("bp_hold_ch", 64'(out_channel), 64'd0);
        check_eq("bp_hold_v",  64'(out_valid),   64'd1);
        ready = 1'b1;
        drain("bp");
        ovf_clr[1] = 1'b1;
        tick();
        check_eq("bp_ovf_clr", 64'(ovf), 64'd0);

        // New ch1 tag in the same cycle its pending tag is granted.
        ready = 1'b0;
        set_auto(0, 1'b1);
        tick();
        tick();
        set_auto(1, 1'b1);
        tick();
        ready = 1'b1;
        set_auto(1, 1'b1);
        tick();
        check_eq("same_cyc_ovf", 64'(ovf), 64'd0);
        drain("same_cyc");
        check_eq("same_cyc_ovf_end", 64'(ovf), 64'd0);

        // Enable low: strobe ignored entirely.
        enable = 1'b0;
        set_auto(0, 1'b0);
        tick();
        idle(4);
        check_eq("en_valid", 64'(out_valid), 64'd0);
        check_eq("en_ovf",   64'(ovf),       64'd0);
        enable = 1'b1;

        // Overflow set and clear in the same cycle keeps the flag.
        ready = 1'b0;
        set_auto(3, 1'b1);
        tick();
        tick();
        set_auto(3, 1'b1);
        tick();
        set_auto(3, 1'b0);
        tick();
        check_eq("ovf3_set", 64'(ovf), 64'b1000);
        set_auto(3, 1'b0);
        ovf_clr[3] = 1'b1;
        tick();
        check_eq("ovf3_set_clr", 64'(ovf), 64'b1000);
        ovf_clr[3] = 1'b1;
        tick();
        check_eq("ovf3_clr", 64'(ovf), 64'd0);
        ready = 1'b1;
        drain("ovf3");

        // Sequence wrap: 17 back-to-back tags, seq 0..15,0.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_auto(i % NCH, 1'b1);
            tick();
        end
        drain("wrap");
        check_eq("wrap_ovf", 64'(ovf), 64'd0);

        // Reset mid-stream with an output held and tags pending.
        ready = 1'b0;
        for (int k = 0; k < NCH; k++) set_auto(k, 1'b1);
        tick();
        tick();
        check_eq("mid_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(out_valid),   64'd0);
        check_eq("mid_rst_utc",   64'(out_utc),     64'd0);
        check_eq("mid_rst_chan",  64'(out_channel), 64'd0);
        check_eq("mid_rst_seq",   64'(out_seq),     64'd0);
        sb.delete();
        exp_seq = '0;
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        idle(6);
        check_eq("mid_no_stale", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
